fpadder_arb: RTL and testbench
==============================

# fpadder_arb

Two-port arbiter and sequencer for the shared 8-bit floating-point adder. It accepts add requests from two independent requesters, for example switch/button entry and an accumulator loop. It grants one request at a time with round-robin fairness, drives the adder's start/operand/show_sum controls, waits for the adder's done, and returns the sum with a one-cycle acknowledge to the granted requester. It sits between the requesters and the adder; the adder output continues to feed the seven-segment display path.

## Interface
Parameters:
- TIMEOUT, default 64: WAIT-state watchdog limit in cycles. Only used with FPADDER_ARB_TIMEOUT_EN.
- FW, default 8: float word width (operands and sum).

Ports (one clock `clk`; reset `clr` is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- clr  in  1  synchronous active-high reset
- req0 / req1  in  1  request level from requester 0 / 1
- a0, b0 / a1, b1  in  FW  operands from requester 0 / 1, stable while its req is high
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1
- res  out  FW  registered sum, valid while ack0 or ack1 is high and held afterwards
- err  out  1  timeout flag, valid with ack; always 0 when the macro is off
- busy  out  1  high in any state other than IDLE
- fpa_start  out  1  one-cycle start pulse to the adder
- fpa_a, fpa_b  out  FW  latched operands to the adder
- fpa_show_sum  out  1  display select to the adder: 1 = sum, 0 = operands
- fpa_done  in  1  adder completion strobe (at least one cycle)
- fpa_sum  in  FW  adder result, valid when fpa_done is high

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port not served last. After reset, port 0 has priority.
  - On grant: latch the granted operands into fpa_a/fpa_b, record the grant index, clear fpa_show_sum, go to ISSUE.
- **ISSUE**: assert fpa_start for exactly this one cycle; go to WAIT.
- **WAIT**: on fpa_done=1, capture fpa_sum into res, set err=0, go to RESP.
- **RESP**
  - Pulse ack of the granted port for one cycle and set fpa_show_sum=1.
  - Update the last-served pointer to the granted port; go to IDLE.
- Requester handshake:
  - req must stay high until its ack is sampled high, and drop on that same edge.
  - Operands are sampled only at grant, so requesters may change them after ISSUE.
- fpa_done while not in WAIT is ignored.
- The non-granted req may stay high throughout; it is granted in the next IDLE.
- res, fpa_a and fpa_b hold their values until they are overwritten.
- clr in any state: return to IDLE, drop start/ack immediately, and discard any in-flight result. The adder shares clr.

## Timing
- Reset values:
  - state IDLE, pointer favouring port 0
  - ack0 = ack1 = 0, err = 0, busy = 0
  - fpa_start = 0, fpa_show_sum = 0
  - res = fpa_a = fpa_b = 0
- All outputs are registered.
- Latency:
  - req sampled at edge N → fpa_start high in cycle N+1.
  - fpa_done sampled at edge M → ack high in cycle M+1.
  - Minimum req-to-ack is 3 cycles.
- Throughput: back-to-back grants have one IDLE cycle between RESP and the next ISSUE.

## Configuration
- FPADDER_ARB_TIMEOUT_EN defined:
  - A WAIT-cycle counter (width clog2(TIMEOUT+1)) clears on entering WAIT.
  - When it reaches TIMEOUT without fpa_done, go to RESP with err=1 and res=0.
  - fpa_done and timeout on the same edge: done wins and err=0.
- Undefined: WAIT waits indefinitely, err is tied 0, and no counter is built.

## Structure
- Shared package fpadder_pkg:
  - FW
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP)
  - default TIMEOUT constant
- One sub-module: rr_pick2 (combinational 2-way round-robin pick from {req1, req0} plus last-served bit → grant index and grant-valid).
- The FSM, latches and watchdog live in fpadder_arb.

## Test plan
The bench uses a behavioural adder model: done is asserted LAT cycles after start, and fpa_sum is a scripted value.
1. req0, a0=8'h3C, b0=8'h40, LAT=4, model sum 8'h44 → one fpa_start pulse, fpa_a=8'h3C, fpa_b=8'h40; ack0 one cycle after done with res=8'h44, err=0, fpa_show_sum=1.
2. req0 and req1 raised on the same edge after reset → port 0 served first, then port 1. Repeat the pair → port 0 then port 1 again; no port is served twice in a row while the other waits.
3. req1 held through three consecutive transactions while req0 toggles → grants alternate 0,1,0,1 and ack1 never fires without a preceding grant.
4. clr asserted during WAIT, then fpa_done one cycle later → no ack and busy=0 the cycle after clr; the next req0 completes normally.
5. Macro on, TIMEOUT=8, model never asserts done → ack0 with err=1 and res=0 exactly 8 WAIT cycles after ISSUE. With the macro off, busy stays high for 100 cycles.
6. LAT=0-equivalent (done in the first WAIT cycle) → req-to-ack is exactly 3 cycles.

Source files
------------

// File: rtl/fpadder_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
package fpadder_pkg;
  localparam int FW          = 8;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/fpadder_arb_rr_pick2.sv
// Two-way round-robin pick: with both requesting, the port not served last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       vld_o
);
  always_comb begin
    vld_o = |req_i;
    gnt_o = 1'b0;
    case (req_i)
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/fpadder_arb.sv
// Round-robin arbiter/sequencer in front of the shared FP adder.
// Optional WAIT watchdog is built when FPADDER_ARB_TIMEOUT_EN is defined.
module fpadder_arb #(
  parameter int TIMEOUT = fpadder_pkg::TIMEOUT_DEF,
  parameter int FW      = fpadder_pkg::FW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic [FW-1:0] a0,
  input  logic [FW-1:0] b0,
  input  logic [FW-1:0] a1,
  input  logic [FW-1:0] b1,
  output logic          ack0,
  output logic          ack1,
  output logic [FW-1:0] res,
  output logic          err,
  output logic          busy,
  output logic          fpa_start,
  output logic [FW-1:0] fpa_a,
  output logic [FW-1:0] fpa_b,
  output logic          fpa_show_sum,
  input  logic          fpa_done,
  input  logic [FW-1:0] fpa_sum
);
  import fpadder_pkg::*;

  arb_state_t    state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic [FW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic          start_q, start_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic          show_q, show_d, busy_q, busy_d;
  logic          pick_gnt, pick_vld;

  rr_pick2 u_pick (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .vld_o  (pick_vld)
  );

`ifdef FPADDER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic          err_q, err_d;
  assign cnt_nx = cnt_q + 1'b1;
  assign err    = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign err            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    show_d  = show_q;
    start_d = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef FPADDER_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (pick_vld) begin
        gnt_d   = pick_gnt;
        a_d     = pick_gnt ? a1 : a0;
        b_d     = pick_gnt ? b1 : b0;
        show_d  = 1'b0;
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FPADDER_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (fpa_done) begin
          res_d   = fpa_sum;
          show_d  = 1'b1;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = RESP;
`ifdef FPADDER_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_nx == CW'(TIMEOUT)) begin
          // Watchdog expiry reports a zero result flagged by err.
          res_d   = '0;
          err_d   = 1'b1;
          show_d  = 1'b1;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_nx;
`endif
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      last_q  <= 1'b1;   // "port 1 served last" gives port 0 first pick
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      show_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FPADDER_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      start_q <= start_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      show_q  <= show_d;
      busy_q  <= busy_d;
`ifdef FPADDER_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign res          = res_q;
  assign busy         = busy_q;
  assign fpa_start    = start_q;
  assign fpa_a        = a_q;
  assign fpa_b        = b_q;
  assign fpa_show_sum = show_q;
endmodule

// File: tb/tb_fpadder_arb.sv
// Randomized bench for fpadder_arb with a behavioural adder and round-robin model.
module tb_fpadder_arb;
  localparam int FW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic clr, req0, req1, fpa_done;
  logic [FW-1:0] a0, b0, a1, b1, fpa_sum;
  logic ack0, ack1, err, busy, fpa_start, fpa_show_sum;
  logic [FW-1:0] res, fpa_a, fpa_b;

  int n_tests = 0;
  int n_fail  = 0;

  // adder model controls: m_lat = WAIT cycles before done (negative = never)
  int m_lat = 0;
  int m_cnt = 0;
  bit m_armed = 0;
  bit ovr_en = 0;
  logic [FW-1:0] ovr_val = '0;
  logic [FW-1:0] lat_a = '0, lat_b = '0;
  bit m_last = 1'b1;  // reference pointer: port served last

  fpadder_arb #(.TIMEOUT(TO), .FW(FW)) dut (
    .clk(clk), .clr(clr), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .res(res), .err(err), .busy(busy),
    .fpa_start(fpa_start), .fpa_a(fpa_a), .fpa_b(fpa_b),
    .fpa_show_sum(fpa_show_sum), .fpa_done(fpa_done), .fpa_sum(fpa_sum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    fpa_done = 1'b0;
    if (fpa_start) begin
      m_armed = 1; m_cnt = m_lat; lat_a = fpa_a; lat_b = fpa_b;
    end else if (m_armed && m_lat >= 0) begin
      if (m_cnt == 0) begin
        fpa_done = 1'b1;
        fpa_sum  = ovr_en ? ovr_val : lat_a + lat_b;
        m_armed  = 0;
      end else m_cnt--;
    end
  end

  function automatic int exp_port(input logic r0, input logic r1, input bit last);
    if (r0 && r1) return last ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  task automatic do_clr();
    clr = 1; req0 = 0; req1 = 0;
    @(negedge clk); @(negedge clk);
    clr = 0; m_last = 1'b1;
  endtask

  task automatic wait_ack(input int maxc, input bit keep0, input bit keep1,
                          output int port, output logic [FW-1:0] r, output logic e,
                          output logic ss, output logic [FW-1:0] fa, output logic [FW-1:0] fb,
                          output int nst, output int st_cyc, output int ncyc);
    port = -1; r = '0; e = 0; ss = 0; fa = '0; fb = '0; nst = 0; st_cyc = -1; ncyc = 0;
    while (ncyc < maxc) begin
      @(negedge clk); ncyc++;
      if (fpa_start) begin nst++; st_cyc = ncyc; fa = fpa_a; fb = fpa_b; end
      if (ack0 || ack1) begin
        port = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        r = res; e = err; ss = fpa_show_sum;
        if (ack0 && !keep0) req0 = 0;
        if (ack1 && !keep1) req1 = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_clr();
    n_tests++;
    if ({ack0, ack1, err, busy, fpa_start, fpa_show_sum} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 000000", {ack0, ack1, err, busy, fpa_start, fpa_show_sum});
    end
    n_tests++;
    if ({res, fpa_a, fpa_b} !== 24'h0) begin
      n_fail++; $display("FAIL reset_data got %h want 000000", {res, fpa_a, fpa_b});
    end
  endtask

  task automatic test_single();
    int p, nst, sc, nc; logic [FW-1:0] r, fa, fb; logic e, ss;
    m_lat = 4; ovr_en = 1; ovr_val = 8'h44;
    a0 = 8'h3C; b0 = 8'h40; req0 = 1;
    wait_ack(40, 0, 0, p, r, e, ss, fa, fb, nst, sc, nc);
    n_tests++;
    if (p !== 0 || nst !== 1) begin n_fail++; $display("FAIL single_grant got port %0d starts %0d want 0 1", p, nst); end
    n_tests++;
    if ({fa, fb} !== 16'h3C40) begin n_fail++; $display("FAIL single_ops got %h want 3c40", {fa, fb}); end
    n_tests++;
    if (r !== 8'h44 || e !== 0 || ss !== 1) begin
      n_fail++; $display("FAIL single_resp got res %h err %b show %b want 44 0 1", r, e, ss);
    end
    m_last = 0;
    @(negedge clk);
    n_tests++;
    if (ack0 !== 0 || res !== 8'h44) begin n_fail++; $display("FAIL single_hold got ack %b res %h want 0 44", ack0, res); end
    ovr_en = 0;
  endtask

  task automatic test_pair();
    int p, e_p, nst, sc, nc; logic [FW-1:0] r, fa, fb, e_r; logic e, ss;
    do_clr();
    for (int rep = 0; rep < 2; rep++) begin
      a0 = FW'($urandom); b0 = FW'($urandom); a1 = FW'($urandom); b1 = FW'($urandom);
      req0 = 1; req1 = 1;
      for (int k = 0; k < 2; k++) begin
        e_p = exp_port(req0, req1, m_last);
        e_r = e_p ? a1 + b1 : a0 + b0;
        m_lat = $urandom_range(0, 5);
        wait_ack(40, 0, 0, p, r, e, ss, fa, fb, nst, sc, nc);
        n_tests++;
        if (p !== k || p !== e_p || r !== e_r) begin
          n_fail++; $display("FAIL pair_%0d_%0d got port %0d res %h want %0d %h", rep, k, p, r, k, e_r);
        end
        m_last = p[0];
      end
    end
  endtask

  task automatic test_back_to_back();
    int p, e_p, nst, sc, nc; logic [FW-1:0] r, fa, fb, e_r; logic e, ss;
    do_clr();
    a0 = FW'($urandom); b0 = FW'($urandom); a1 = FW'($urandom); b1 = FW'($urandom);
    req0 = 1; req1 = 1;
    for (int t = 0; t < 4; t++) begin
      e_p = exp_port(req0, req1, m_last);
      e_r = e_p ? a1 + b1 : a0 + b0;
      m_lat = $urandom_range(0, 3);
      wait_ack(40, 0, (t < 3), p, r, e, ss, fa, fb, nst, sc, nc);
      n_tests++;
      if (p !== (t % 2) || p !== e_p || r !== e_r || nst !== 1) begin
        n_fail++; $display("FAIL b2b_%0d got port %0d res %h starts %0d want %0d %h 1", t, p, r, nst, t % 2, e_r);
      end
      if (t > 0) begin
        n_tests++;
        if (sc !== 2) begin n_fail++; $display("FAIL b2b_gap_%0d got %0d want 2", t, sc); end
      end
      m_last = p[0];
      if (p == 0) begin req0 = (t < 2); a0 = FW'($urandom); b0 = FW'($urandom); end
      else begin a1 = FW'($urandom); b1 = FW'($urandom); end
    end
  endtask

  task automatic test_clr_wait();
    int p, nst, sc, nc, g; logic [FW-1:0] r, fa, fb, e_r; logic e, ss;
    m_lat = 2; a0 = FW'($urandom); b0 = FW'($urandom); req0 = 1;
    g = 0;
    while (!fpa_start && g < 10) begin @(negedge clk); g++; end
    n_tests++;
    if (!fpa_start) begin n_fail++; $display("FAIL clr_start got no start want start"); end
    @(negedge clk); @(negedge clk);
    clr = 1; req0 = 0;
    @(negedge clk);
    clr = 0; m_last = 1'b1;
    n_tests++;
    if ({busy, ack0, ack1, fpa_start} !== 4'b0 || res !== '0) begin
      n_fail++; $display("FAIL clr_after got busy/ack/start %b res %h want 0000 00", {busy, ack0, ack1, fpa_start}, res);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, ack0, ack1} !== 3'b0) begin
        n_fail++; $display("FAIL clr_late_done_%0d got %b want 000", i, {busy, ack0, ack1});
      end
    end
    a0 = FW'($urandom); b0 = FW'($urandom); e_r = a0 + b0; req0 = 1; m_lat = 1;
    wait_ack(40, 0, 0, p, r, e, ss, fa, fb, nst, sc, nc);
    n_tests++;
    if (p !== 0 || r !== e_r || e !== 0) begin n_fail++; $display("FAIL clr_recover got port %0d res %h want 0 %h", p, r, e_r); end
    m_last = 0;
  endtask

  task automatic test_timeout();
    int p, nst, sc, nc; logic [FW-1:0] r, fa, fb, e_r; logic e, ss;
`ifdef FPADDER_ARB_TIMEOUT_EN
    m_lat = -1; a0 = FW'($urandom) | 8'h01; b0 = FW'($urandom); req0 = 1;
    wait_ack(60, 0, 0, p, r, e, ss, fa, fb, nst, sc, nc);
    n_tests++;
    if (p !== 0 || e !== 1 || r !== '0) begin n_fail++; $display("FAIL timeout_resp got port %0d err %b res %h want 0 1 00", p, e, r); end
    n_tests++;
    if (nc - sc !== TO + 1) begin n_fail++; $display("FAIL timeout_len got %0d want %0d", nc - sc, TO + 1); end
    m_last = 0;
    m_lat = TO - 1; a1 = FW'($urandom); b1 = FW'($urandom); e_r = a1 + b1; req1 = 1;
    wait_ack(60, 0, 0, p, r, e, ss, fa, fb, nst, sc, nc);
    n_tests++;
    if (p !== 1 || e !== 0 || r !== e_r) begin n_fail++; $display("FAIL timeout_tie got port %0d err %b res %h want 1 0 %h", p, e, r, e_r); end
    m_last = 1;
`else
    int lows;
    m_lat = -1; a0 = FW'($urandom); b0 = FW'($urandom); req0 = 1;
    lows = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy || ack0 || ack1) lows++;
    end
    n_tests++;
    if (lows !== 0) begin n_fail++; $display("FAIL hang_busy got %0d idle cycles want 0", lows); end
    do_clr();
`endif
  endtask

  task automatic test_latency();
    int p, nst, sc, nc; logic [FW-1:0] r, fa, fb; logic e, ss;
    do_clr();
    m_lat = 0; a0 = FW'($urandom); b0 = FW'($urandom); req0 = 1;
    wait_ack(20, 0, 0, p, r, e, ss, fa, fb, nst, sc, nc);
    n_tests++;
    if (p !== 0 || nc !== 3) begin n_fail++; $display("FAIL latency got port %0d cycles %0d want 0 3", p, nc); end
    m_last = 0;
  endtask

  task automatic test_random();
    int p, e_p, nst, sc, nc, pat; logic [FW-1:0] r, fa, fb, e_r; logic e, ss;
    for (int it = 0; it < 20; it++) begin
      pat = $urandom_range(0, 2);
      a0 = FW'($urandom); b0 = FW'($urandom); a1 = FW'($urandom); b1 = FW'($urandom);
      req0 = (pat != 1); req1 = (pat != 0);
      while (req0 || req1) begin
        e_p = exp_port(req0, req1, m_last);
        e_r = e_p ? a1 + b1 : a0 + b0;
        m_lat = $urandom_range(0, 6);
        wait_ack(40, 0, 0, p, r, e, ss, fa, fb, nst, sc, nc);
        n_tests++;
        if (p !== e_p || r !== e_r || e !== 0 || ss !== 1 || nst !== 1) begin
          n_fail++;
          $display("FAIL rand_%0d got port %0d res %h err %b starts %0d want %0d %h 0 1", it, p, r, e, nst, e_p, e_r);
        end
        if (p < 0 || p > 1) begin req0 = 0; req1 = 0; do_clr(); end
        else m_last = p[0];
      end
    end
  endtask

  initial begin
    clr = 1; req0 = 0; req1 = 0; fpa_done = 0; fpa_sum = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_pair();
    test_back_to_back();
    test_clr_wait();
    test_timeout();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
